// File: rtl/instr_encode_loader_pkg.sv
// Shared constants for the instruction encode/loader: RV32I opcodes,
// request-kind encodings and the loader FSM state encoding.
package instr_encode_loader_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    K_RTYPE  = 2'b00,
    K_LOAD   = 2'b01,
    K_STORE  = 2'b10,
    K_BRANCH = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/instr_encode_loader_packer.sv
// Combinational field packer: turns one field-level request into a
// 32-bit RV32I instruction word for the four supported opcode classes.
module instr_field_packer
  import instr_encode_loader_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  // Select the instruction layout by kind; branch imm already holds off[12:1].
  always_comb begin
    word = 32'h0;
    case (kind_e'(kind))
      K_RTYPE:  word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
      K_LOAD:   word = {imm, rs1, funct3, rd, OP_LOAD};
      K_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      K_BRANCH: word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
      default:  word = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams encoded instructions into instruction memory at sequential word
// addresses. One request accepted in IDLE, written in the following WRITE
// cycle, so sustained throughput is one instruction per two cycles.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [11:0]       req_imm,
  input  logic              req_last,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done
);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [31:0]       wdata_q;
  logic              last_q;
  logic              done_q;
  logic [31:0]       packed_word;

  instr_field_packer u_packer (
    .kind     (req_kind),
    .funct3   (req_funct3),
    .funct7b5 (req_funct7b5),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (req_imm),
    .word     (packed_word)
  );

  // Loader FSM: capture on handshake, write for one cycle, park in DONE
  // after the last request or when memory is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wdata_q <= packed_word;
            last_q  <= req_last;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          ptr <= ptr + 1'b1;
          cnt <= cnt + 1'b1;
          if (last_q || (ptr == ADDR_W'(DEPTH - 1))) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (clear) begin
            ptr    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write enable is gated by rst so a write caught by reset is dropped
  // in the same cycle rather than one cycle late.
  assign imem_we    = (state == S_WRITE) && !rst;
  assign req_ready  = (state == S_IDLE);
  assign imem_addr  = ptr;
  assign imem_wdata = wdata_q;
  assign count      = cnt;
  assign done       = done_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed table from the instruction
// examples, DONE/clear/full-memory/reset corner sequences, and randomized
// requests checked against an arithmetic encoding model.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [11:0] req_imm;
  logic        req_last;
  logic        clear;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;
  logic        done;

  int vecs = 0;
  int errs = 0;

  instr_encode_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_funct3   (req_funct3),
    .req_funct7b5 (req_funct7b5),
    .req_rd       (req_rd),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_imm      (req_imm),
    .req_last     (req_last),
    .clear        (clear),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .count        (count),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        last;
    logic [5:0]  eaddr;
    logic [31:0] eword;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference encoder built from field positions with plain arithmetic;
  // branches are expressed through the full byte offset.
  function automatic logic [31:0] model_enc(input int k, input int f3, input int f7,
                                            input int rd, input int rs1, input int rs2,
                                            input int imm);
    int off;
    int w;
    w = (rs1 << 15) | (f3 << 12);
    case (k)
      0: w = w | (f7 << 30) | (rs2 << 20) | (rd << 7) | 'h33;
      1: w = w | (imm << 20) | (rd << 7) | 'h03;
      2: w = w | ((imm >> 5) << 25) | (rs2 << 20) | ((imm % 32) << 7) | 'h23;
      default: begin
        off = imm * 2;
        w = w | (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (rs2 << 20)
              | (((off >> 1) & 15) << 8) | (((off >> 11) & 1) << 7) | 'h63;
      end
    endcase
    return w;
  endfunction

  // One request: handshake from IDLE, check the write cycle, return to
  // the cycle after the write. clr is held through the request to show
  // it has no effect outside DONE.
  task automatic do_req(input logic [1:0] k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [11:0] imm, input logic last, input logic clr,
                        input logic [5:0] ea, input logic [31:0] ew);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_kind = k; req_funct3 = f3; req_funct7b5 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_last = last; clear = clr; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("we_write", {31'b0, imem_we}, 32'd1);
    chk("addr", {26'b0, imem_addr}, {26'b0, ea});
    chk("wdata", imem_wdata, ew);
    chk("ready_write", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    req_last = 1'b0;
    chk("we_after", {31'b0, imem_we}, 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_done", {31'b0, done}, 32'd0);
    chk("clr_count", {25'b0, count}, 32'd0);
    chk("clr_addr", {26'b0, imem_addr}, 32'd0);
    chk("clr_ready", {31'b0, req_ready}, 32'd1);
  endtask

  vec_t tbl[4];
  int   exp_ptr;
  logic [31:0] w, last_w;

  initial begin
    tbl[0] = '{2'b00, 3'b110, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000, 1'b0, 6'd0, 32'h007362B3};
    tbl[1] = '{2'b01, 3'b010, 1'b0, 5'd6, 5'd9, 5'd0, 12'hFFC, 1'b0, 6'd1, 32'hFFC4A303};
    tbl[2] = '{2'b10, 3'b010, 1'b0, 5'd0, 5'd9, 5'd6, 12'h008, 1'b0, 6'd2, 32'h0064A423};
    tbl[3] = '{2'b11, 3'b000, 1'b0, 5'd0, 5'd4, 5'd4, 12'hFFC, 1'b1, 6'd3, 32'hFE420CE3};

    rst = 1'b1; req_valid = 1'b0; req_kind = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_last = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_we", {31'b0, imem_we}, 32'd0);
    chk("rst_addr", {26'b0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", {25'b0, count}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      do_req(tbl[i].kind, tbl[i].f3, tbl[i].f7, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
             tbl[i].imm, tbl[i].last, 1'b0, tbl[i].eaddr, tbl[i].eword);
      if (i == 1) begin
        // no handshake: wdata held, no write
        repeat (2) @(posedge clk); #1;
        chk("hold_wdata", imem_wdata, tbl[i].eword);
        chk("hold_we", {31'b0, imem_we}, 32'd0);
      end
    end
    chk("last_done", {31'b0, done}, 32'd1);
    chk("last_count", {25'b0, count}, 32'd4);
    chk("last_ready", {31'b0, req_ready}, 32'd0);

    // Requests in DONE are ignored
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done_nowrite", {31'b0, imem_we}, 32'd0);
      chk("done_count", {25'b0, count}, 32'd4);
    end
    req_valid = 1'b0;
    pulse_clear();

    // Full memory: 64 writes with last=0; clear held throughout is ignored
    for (int i = 0; i < 64; i++) begin
      req_kind = 2'($urandom_range(0, 3));
      req_funct3 = 3'($urandom); req_funct7b5 = 1'($urandom);
      req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_imm = 12'($urandom);
      w = model_enc(int'(req_kind), int'(req_funct3), int'(req_funct7b5), int'(req_rd),
                    int'(req_rs1), int'(req_rs2), int'(req_imm));
      do_req(req_kind, req_funct3, req_funct7b5, req_rd, req_rs1, req_rs2, req_imm,
             1'b0, 1'($urandom), 6'(i), w);
      if (i < 63) chk("full_notdone", {31'b0, done}, 32'd0);
    end
    chk("full_done", {31'b0, done}, 32'd1);
    chk("full_count", {25'b0, count}, 32'd64);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("full_65_ready", {31'b0, req_ready}, 32'd0);
      chk("full_65_we", {31'b0, imem_we}, 32'd0);
    end
    req_valid = 1'b0;
    pulse_clear();

    // Reset in the WRITE cycle drops the write and restarts at address 0
    do_req(2'b00, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 12'h0, 1'b0, 1'b0, 6'd0,
           model_enc(0, 0, 1, 1, 2, 3, 0));
    do_req(2'b01, 3'b011, 1'b0, 5'd4, 5'd5, 5'd0, 12'h123, 1'b0, 1'b0, 6'd1,
           model_enc(1, 3, 0, 4, 5, 0, 'h123));
    req_kind = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rst_write_we", {31'b0, imem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_count", {25'b0, count}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    do_req(2'b11, 3'b001, 1'b0, 5'd0, 5'd7, 5'd8, 12'h010, 1'b0, 1'b0, 6'd0,
           model_enc(3, 1, 0, 0, 7, 8, 'h010));

    // Randomized requests against the model, including random last and gaps
    exp_ptr = 1;
    last_w = '0;
    for (int i = 0; i < 120; i++) begin
      req_kind = 2'($urandom_range(0, 3));
      req_funct3 = 3'($urandom); req_funct7b5 = 1'($urandom);
      req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_imm = 12'($urandom);
      w = model_enc(int'(req_kind), int'(req_funct3), int'(req_funct7b5), int'(req_rd),
                    int'(req_rs1), int'(req_rs2), int'(req_imm));
      do_req(req_kind, req_funct3, req_funct7b5, req_rd, req_rs1, req_rs2, req_imm,
             1'($urandom_range(0, 9) == 0), 1'($urandom), 6'(exp_ptr), w);
      exp_ptr++;
      chk("rnd_count", {25'b0, count}, 32'(exp_ptr));
      if (done) begin
        pulse_clear();
        exp_ptr = 0;
      end else if (exp_ptr >= 64) begin
        chk("rnd_full_done", {31'b0, done}, 32'd1);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rnd_hold", imem_wdata, w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Streams encoded RV32I instructions into the single-cycle core's instruction memory through its write port.
- Accepts field-level requests (kind, registers, funct3, immediate) over a valid/ready handshake and packs each one into a 32-bit instruction word.
- Each word is written to sequential word addresses, so benches and boot logic can build a program without hand-assembled hex.
- Covers the four opcode classes the control unit decodes: R-type, load, store and branch.

Parameters:
- DEPTH, 64, number of instruction-memory words that can be written.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  loader can accept a request this cycle.
- req_kind  in  2  00 R-type, 01 load, 10 store, 11 branch.
- req_funct3  in  3  funct3 field.
- req_funct7b5  in  1  bit 30 of the instruction (R-type only).
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2.
- req_imm  in  12  imm[11:0] for load/store; byte offset[12:1] for branch.
- req_last  in  1  this request is the final instruction of the program.
- clear  in  1  leave DONE; restart at address 0.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written so far.
- done  out  1  load complete.

Behaviour:
- Reset (synchronous, active-high) returns every output and internal register to its reset value:
  - state IDLE; write pointer and count 0; imem_we 0; imem_addr 0; imem_wdata 0; done 0.
  - A write pending in WRITE when reset is asserted is dropped (imem_we stays 0).
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid & req_ready) registers the encoded word into imem_wdata, registers req_last, and moves to WRITE.
  - With no handshake, the FSM stays in IDLE and imem_wdata holds its value.
- WRITE:
  - req_ready = 0.
  - imem_we = 1 for exactly this one cycle, with imem_addr = write pointer.
  - On exit, the pointer and count increment.
  - Next state is DONE if the registered last flag is set or the pointer equals DEPTH-1; otherwise IDLE.
- DONE:
  - req_ready = 0; done = 1; requests are ignored.
  - clear = 1 sets pointer = 0, count = 0, done = 0 and moves to IDLE.
  - clear is ignored in IDLE and WRITE.
- Throughput and latency:
  - One instruction per 2 cycles.
  - Handshake in cycle N produces imem_we in cycle N+1.
- Encoding ({} is MSB to LSB):
  - R-type: {0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011}.
  - Load: {imm[11:0], rs1, funct3, rd, 0000011}.
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - Branch, where req_imm = off[12:1]: {req_imm[11], req_imm[9:4], rs2, rs1, funct3, req_imm[3:0], req_imm[10], 1100011}.
  - Fields a kind does not use are ignored; e.g. req_rd has no effect on store or branch.
- Wrap-around: none. The block stops in DONE after DEPTH writes, so count reaches DEPTH at most and imem_addr never exceeds DEPTH-1.
- imem_addr and imem_wdata are held outside WRITE; they only matter while imem_we = 1.

Decomposition:
- Shared package holds:
  - the opcode constants OP_RTYPE 0110011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011;
  - the req_kind encodings;
  - the FSM state encoding.
  - The main decoder uses the same opcode constants.
- One combinational sub-module, instr_field_packer: request fields in, 32-bit word out.
- The FSM, pointer and count live in the top module.

Test Plan:
- R-type: kind 00, funct3 110, funct7b5 0, rd 5, rs1 6, rs2 7 -> one cycle later imem_we = 1, addr 0, wdata 0x007362B3.
- Load: kind 01, funct3 010, rd 6, rs1 9, imm 0xFFC -> wdata 0xFFC4A303 at addr 1.
- Store: kind 10, funct3 010, rs1 9, rs2 6, imm 0x008 -> wdata 0x0064A423 at addr 2.
- Branch: kind 11, funct3 000, rs1 4, rs2 4, imm 0xFFC (offset -8) -> wdata 0xFE420CE3 at addr 3.
  - Sending req_last = 1 with this request -> done = 1, count = 4, req_ready = 0.
  - Further req_valid in DONE produces no write.
  - Pulsing clear -> addr 0, count 0, done 0, req_ready = 1.
- Full memory: 64 back-to-back requests with req_last = 0 -> writes at addresses 0..63, then done = 1 and count = 64; a 65th request is never accepted.
- Reset mid-operation: assert rst in the WRITE cycle -> imem_we = 0 that cycle; after release, req_ready = 1 and the next write goes to addr 0.
